// File: rtl/rst_seq.sv
// rst_seq: multi-domain reset sequencer. Releases peripheral, memory-controller
// and CPU resets in order with programmable gaps. CPU release waits for memory
// ready, with an optional timeout. Also runs a software warm reset that keeps
// the memory controller out of reset.
module rst_seq #(
  parameter int unsigned DLY_PERIPH = 16,
  parameter int unsigned DLY_MEM    = 16,
  parameter int unsigned DLY_CPU    = 64,
  parameter int unsigned MEM_TO     = 65535,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mem_ready,
  input  logic       i_sw_rst,
  output logic       o_rst_periph,
  output logic       o_rst_mem,
  output logic       o_rst_cpu,
  output logic       o_seq_done,
  output logic       o_mem_timeout,
  output logic [1:0] o_rst_cause
);

  typedef enum logic [2:0] {
    HOLD,
    PERIPH,
    MEM,
    WAIT_RDY,
    CPU,
    RUN,
    WARM_PERIPH,
    WARM_CPU
  } state_t;

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] LAST_PERIPH = CNT_W'(DLY_PERIPH - 1);
  localparam logic [CNT_W-1:0] LAST_MEM    = CNT_W'(DLY_MEM - 1);
  localparam logic [CNT_W-1:0] LAST_CPU    = CNT_W'(DLY_CPU - 1);
  localparam logic [CNT_W-1:0] LAST_TO     = CNT_W'(MEM_TO - 1);
  localparam logic             TO_EN       = 1'(MEM_TO != 0);
  localparam logic [1:0]       CAUSE_EXT   = 2'b01;
  localparam logic [1:0]       CAUSE_SW    = 2'b10;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Sequencer FSM: the single shared counter clears on every state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= HOLD;
      cnt           <= '0;
      o_rst_periph  <= 1'b1;
      o_rst_mem     <= 1'b1;
      o_rst_cpu     <= 1'b1;
      o_seq_done    <= 1'b0;
      o_mem_timeout <= 1'b0;
      o_rst_cause   <= CAUSE_EXT;
    end else begin
      case (state)
        HOLD: begin
          state <= PERIPH;
          cnt   <= '0;
        end

        PERIPH: begin
          if (cnt == LAST_PERIPH) begin
            state        <= MEM;
            cnt          <= '0;
            o_rst_periph <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        MEM: begin
          if (cnt == LAST_MEM) begin
            state     <= WAIT_RDY;
            cnt       <= '0;
            o_rst_mem <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Ready wins over a timeout landing on the same edge; a timeout still
        // releases the CPU so boot firmware can report it.
        WAIT_RDY: begin
          if (i_mem_ready) begin
            state <= CPU;
            cnt   <= '0;
          end else if (TO_EN && (cnt == LAST_TO)) begin
            state         <= CPU;
            cnt           <= '0;
            o_mem_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CPU: begin
          if (cnt == LAST_CPU) begin
            state      <= RUN;
            cnt        <= '0;
            o_rst_cpu  <= 1'b0;
            o_seq_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Memory ready is not watched here; only a software request acts.
        RUN: begin
          if (i_sw_rst) begin
            state        <= WARM_PERIPH;
            cnt          <= '0;
            o_rst_periph <= 1'b1;
            o_rst_cpu    <= 1'b1;
            o_seq_done   <= 1'b0;
            o_rst_cause  <= CAUSE_SW;
          end
        end

        WARM_PERIPH: begin
          if (cnt == LAST_PERIPH) begin
            state        <= WARM_CPU;
            cnt          <= '0;
            o_rst_periph <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WARM_CPU: begin
          if (cnt == LAST_CPU) begin
            state      <= RUN;
            cnt        <= '0;
            o_rst_cpu  <= 1'b0;
            o_seq_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: table-driven, directed and random checks of rst_seq. Two
// instances share all inputs and differ only in memory-ready timeout.
module tb_rst_seq;

  localparam int DP   = 4;
  localparam int DM   = 3;
  localparam int DC   = 5;
  localparam int TO_L = 100;
  localparam int TO_T = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic sw  = 1'b0;

  logic       l_p, l_m, l_c, l_d, l_t;
  logic [1:0] l_cause;
  logic       t_p, t_m, t_c, t_d, t_t;
  logic [1:0] t_cause;

  rst_seq #(.DLY_PERIPH(DP), .DLY_MEM(DM), .DLY_CPU(DC), .MEM_TO(TO_L), .CNT_W(16)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_mem_ready(rdy), .i_sw_rst(sw),
    .o_rst_periph(l_p), .o_rst_mem(l_m), .o_rst_cpu(l_c), .o_seq_done(l_d),
    .o_mem_timeout(l_t), .o_rst_cause(l_cause)
  );

  rst_seq #(.DLY_PERIPH(DP), .DLY_MEM(DM), .DLY_CPU(DC), .MEM_TO(TO_T), .CNT_W(16)) dut_t (
    .i_clk(clk), .i_rst(rst), .i_mem_ready(rdy), .i_sw_rst(sw),
    .o_rst_periph(t_p), .o_rst_mem(t_m), .o_rst_cpu(t_c), .o_seq_done(t_d),
    .o_mem_timeout(t_t), .o_rst_cause(t_cause)
  );

  // Timeline model: outputs derived from the edge numbers of the sequence
  // start and of the event that qualifies the CPU countdown.
  typedef struct {
    bit         hold;
    bit         warm;
    int         t_start;
    int         t_q;
    bit         to;
    logic [1:0] cause;
  } mdl_t;

  typedef struct {
    bit         r;
    bit         y;
    bit         w;
    int         reps;
    logic [6:0] e;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   n     = 0;
  mdl_t ml, mt;

  // Expected {periph, mem, cpu, done, timeout, cause} after edge n.
  function automatic logic [6:0] expv(mdl_t s, int k);
    bit p, m, c;
    p = s.hold || (k < s.t_start + DP);
    m = s.hold || (!s.warm && (k < s.t_start + DP + DM));
    c = s.hold || (s.t_q < 0) || (k < s.t_q + DC);
    return {p, m, c, !c, s.to, s.cause};
  endfunction

  function automatic mdl_t step(mdl_t s, bit r, bit y, bit w, int k, int mem_to);
    logic [6:0] prev;
    int         tm;
    prev = expv(s, k - 1);
    tm   = s.t_start + DP + DM;
    if (r) begin
      s.hold = 1; s.warm = 0; s.t_q = -1; s.to = 0; s.cause = 2'b01;
    end else if (s.hold) begin
      s.hold = 0; s.warm = 0; s.t_start = k; s.t_q = -1;
    end else if (prev[3] && w) begin
      s.warm = 1; s.t_start = k; s.t_q = k + DP; s.cause = 2'b10;
    end else if (!s.warm && s.t_q < 0 && k > tm) begin
      if (y) s.t_q = k;
      else if (mem_to != 0 && k == tm + mem_to) begin
        s.t_q = k; s.to = 1;
      end
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, n, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit y, input bit w);
    rst = r; rdy = y; sw = w;
    @(posedge clk);
    n++;
    ml = step(ml, r, y, w, n, TO_L);
    mt = step(mt, r, y, w, n, TO_T);
    #1;
    chk("model_l", {l_p, l_m, l_c, l_d, l_t, l_cause}, expv(ml, n));
    chk("model_t", {t_p, t_m, t_c, t_d, t_t, t_cause}, expv(mt, n));
    chk("order_l", 7'((l_p & ~l_c) | (l_m & ~l_c)), 7'd0);
    chk("order_t", 7'((t_p & ~t_c) | (t_m & ~t_c)), 7'd0);
  endtask

  vec_t tbl[$];

  initial begin
    ml = '{hold: 1, warm: 0, t_start: 0, t_q: -1, to: 0, cause: 2'b01};
    mt = ml;

    // Cold start with ready tied high, warm reset with an ignored second
    // pulse, then loss of ready in RUN.
    tbl.push_back('{1, 1, 0, 2, 7'b1110001});
    tbl.push_back('{0, 1, 0, 4, 7'b1110001});
    tbl.push_back('{0, 1, 0, 3, 7'b0110001});
    tbl.push_back('{0, 1, 0, 6, 7'b0010001});
    tbl.push_back('{0, 1, 0, 3, 7'b0001001});
    tbl.push_back('{0, 1, 1, 1, 7'b1010010});
    tbl.push_back('{0, 1, 0, 3, 7'b1010010});
    tbl.push_back('{0, 1, 0, 2, 7'b0010010});
    tbl.push_back('{0, 1, 1, 1, 7'b0010010});
    tbl.push_back('{0, 1, 0, 2, 7'b0010010});
    tbl.push_back('{0, 1, 0, 2, 7'b0001010});
    tbl.push_back('{0, 0, 0, 3, 7'b0001010});

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        cyc(tbl[i].r, tbl[i].y, tbl[i].w);
        chk("tbl_l", {l_p, l_m, l_c, l_d, l_t, l_cause}, tbl[i].e);
        chk("tbl_t", {t_p, t_m, t_c, t_d, t_t, t_cause}, tbl[i].e);
      end
    end

    // Late ready (first sampled at Tm+20) on dut_l; timeout at Tm+10 on dut_t.
    cyc(1, 0, 0);
    for (int i = 0; i <= 40; i++) begin
      cyc(0, (i >= 27), 0);
      if (i == 16) chk("to_before", 7'(t_t), 7'd0);
      if (i == 17) chk("to_rise", 7'(t_t), 7'd1);
      if (i == 21) chk("to_cpu_held", 7'(t_c), 7'd1);
      if (i == 22) chk("to_cpu_rel", {t_c, t_d}, 7'b01);
      if (i == 31) chk("late_cpu_held", 7'(l_c), 7'd1);
      if (i == 32) chk("late_cpu_rel", {l_c, l_d, l_t}, 7'b010);
    end

    // Timeout flag survives a warm reset.
    cyc(0, 1, 1);
    chk("warm_mem_low", {t_m, t_p, t_c}, 7'b011);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    chk("to_sticky", {t_t, t_d, t_cause}, 7'b1110);

    // External reset mid WARM_PERIPH clears timeout and cause.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("rst_warm_t", {t_p, t_m, t_c, t_d, t_t, t_cause}, 7'b1110001);

    // External reset mid WAIT_RDY, then a full cold replay.
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    chk("in_wait_l", {l_p, l_m, l_c}, 7'b001);
    cyc(1, 0, 0);
    chk("rst_wait_l", {l_p, l_m, l_c, l_d, l_t, l_cause}, 7'b1110001);
    chk("rst_wait_t", {t_p, t_m, t_c, t_d, t_t, t_cause}, 7'b1110001);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0);
    chk("replay_l", {l_p, l_m, l_c, l_d, l_t, l_cause}, 7'b0001001);
    chk("replay_t", {t_p, t_m, t_c, t_d, t_t, t_cause}, 7'b0001001);

    // Random stimulus against the timeline model.
    begin
      bit y;
      y = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) y = ~y;
        cyc(($urandom_range(0, 149) == 0), y, ($urandom_range(0, 15) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
